// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code sequencer.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int CODE_W      = 8;
  localparam int EVT_W       = 10;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;

  function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic brk,
                                                 input logic [CODE_W-1:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-in / event-out bus of the scan-code sequencer. Events use valid/ready:
// a transfer happens on a cycle where evt_valid and evt_ready are both high.
interface ps2_kbd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic       evt_ready;

  modport master (output rx_valid, rx_data, rx_err, evt_ready,
                  input  evt_valid, evt_data);
  modport slave  (input  rx_valid, rx_data, rx_err, evt_ready,
                  output evt_valid, evt_data);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; head is read straight from the storage registers.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 prefix sequencer with event FIFO, held-key tracking and counters.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of the held key.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_kbd_ctrl_if.slave        bus,
  output logic                 key_down,
  output logic [8:0]           key_code,
  output logic [7:0]           press_cnt,
  output logic [7:0]           err_cnt,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output ps2_state_e           fsm_state
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e  state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic        key_down_q, key_down_d;
  logic [8:0]  key_code_q, key_code_d;
  logic [7:0]  press_q, press_d, err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        good, is_ext, is_brk, emit, ev_ext, ev_brk, suppress, push, pop;
  logic        fifo_full, fifo_empty;
  logic [8:0]  ev_code;

  assign good   = bus.rx_valid && !bus.rx_err;
  assign is_ext = (bus.rx_data == PS2_PFX_EXT);
  assign is_brk = (bus.rx_data == PS2_PFX_BRK);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (bus.rx_valid && bus.rx_err) begin
      state_d = ST_IDLE;
    end else if (good) begin
      case (state_q)
        ST_IDLE: begin
          if (is_ext)      state_d = ST_EXT;
          else if (is_brk) state_d = ST_BRK;
          else             emit    = 1'b1;
        end
        ST_EXT: begin
          if (is_brk)      state_d = ST_EXT_BRK;
          else if (!is_ext) begin
            emit = 1'b1; ev_ext = 1'b1; state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (is_ext)      state_d = ST_EXT_BRK;
          else if (!is_brk) begin
            emit = 1'b1; ev_brk = 1'b1; state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (!is_ext && !is_brk) begin
            emit = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; state_d = ST_IDLE;
          end
        end
      endcase
    end else if (state_q != ST_IDLE && to_q == TO_LAST) begin
      state_d = ST_IDLE;
    end
  end

  // Prefix-abandon timer only runs while a prefix is pending.
  assign to_d = (bus.rx_valid || state_d == ST_IDLE) ? '0 : to_q + TW'(1);

  assign ev_code = {ev_ext, bus.rx_data};
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = !ev_brk && key_down_q && (ev_code == key_code_q);
`else
  assign suppress = 1'b0;
`endif
  assign push = emit && !suppress;
  assign pop  = bus.evt_valid && bus.evt_ready;

  always_comb begin
    key_down_d = key_down_q;
    key_code_d = key_code_q;
    press_d    = press_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    if (push && !ev_brk) begin
      key_down_d = 1'b1;
      key_code_d = ev_code;
      press_d    = press_q + 8'd1;
    end else if (push && ev_brk && ev_code == key_code_q) begin
      key_down_d = 1'b0;
    end
    if (bus.rx_valid && bus.rx_err && err_q != 8'hFF) err_d = err_q + 8'd1;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)              ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      to_q       <= '0;
      key_down_q <= 1'b0;
      key_code_q <= '0;
      press_q    <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      key_down_q <= key_down_d;
      key_code_q <= key_code_d;
      press_q    <= press_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (pack_evt(ev_ext, ev_brk, bus.rx_data)),
    .pop_i   (pop),
    .head_o  (bus.evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.evt_valid = !fifo_empty;
  assign key_down      = key_down_q;
  assign key_code      = key_code_q;
  assign press_cnt     = press_q;
  assign err_cnt       = err_q;
  assign ovf           = ovf_q;
  assign fsm_state     = state_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: prefix decoding, FIFO full/overflow, timeout, errors.
module tb_ps2_kbd_ctrl;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_down, ovf, ovf_clr;
  logic [8:0] key_code;
  logic [7:0] press_cnt, err_cnt;
  ps2_state_e fsm_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  ps2_kbd_ctrl_if bus();

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .key_down  (key_down),
    .key_code  (key_code),
    .press_cnt (press_cnt),
    .err_cnt   (err_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // accepted events, sampled mid-cycle ahead of the popping edge
  always @(negedge clk)
    if (!reset && bus.evt_valid && bus.evt_ready) got_q.push_back(bus.evt_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_events(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks; all run from posedge+1
  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_err = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic e = 1'b0);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_err = e;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_err = 1'b0;
  endtask

  initial begin
    bus.evt_ready = 1'b0;
    do_reset();

    // reset values
    chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_evt_data", 32'(bus.evt_data), 32'd0);
    chk("rst_key_down", 32'(key_down), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_press", 32'(press_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));

    // single make, latency N -> N+1
    bus.rx_valid = 1'b1; bus.rx_data = 8'h1C; bus.rx_err = 1'b0;
    #1 chk("t1_no_comb_path", 32'(bus.evt_valid), 32'd0);
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    chk("t1_evt_valid", 32'(bus.evt_valid), 32'd1);
    chk("t1_evt_data", 32'(bus.evt_data), 32'h01C);
    chk("t1_key_down", 32'(key_down), 32'd1);
    chk("t1_key_code", 32'(key_code), 32'h01C);
    chk("t1_press", 32'(press_cnt), 32'd1);
    bus.evt_ready = 1'b1;
    idle(2);
    exp_q.push_back(10'h01C);
    chk_events("t1_evt");

    // make then break
    do_reset();
    send(8'h1C); send(8'hF0);
    chk("t2_state_brk", 32'(fsm_state), 32'(ST_BRK));
    send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h11C);
    chk_events("t2_evt");
    chk("t2_key_down", 32'(key_down), 32'd0);
    chk("t2_press", 32'(press_cnt), 32'd1);

    // extended break
    send(8'hE0);
    chk("t3_state_ext", 32'(fsm_state), 32'(ST_EXT));
    send(8'hF0);
    chk("t3_state_extbrk", 32'(fsm_state), 32'(ST_EXT_BRK));
    send(8'h75);
    chk("t3_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    idle(3);
    exp_q.push_back(10'h375);
    chk_events("t3_evt");

    // break of another key leaves the held key alone
    send(8'h1C); send(8'hF0); send(8'h75);
    chk("t3_nomatch_down", 32'(key_down), 32'd1);
    chk("t3_nomatch_code", 32'(key_code), 32'h01C);
    send(8'hF0); send(8'h1C);
    chk("t3_match_up", 32'(key_down), 32'd0);
    chk("t3_press", 32'(press_cnt), 32'd2);
    idle(3);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h175); exp_q.push_back(10'h11C);
    chk_events("t3_seq");

    // reset in the middle of a prefix
    send(8'hE0);
    do_reset();
    chk("t3_midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    bus.evt_ready = 1'b1;
    send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C);
    chk_events("t3_midrst_evt");

    // FIFO full and overflow
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) send(8'h10 + 8'(i));
    chk("t4_press", 32'(press_cnt), 32'd10);
    chk("t4_ovf_set", 32'(ovf), 32'd1);
    chk("t4_key_code", 32'(key_code), 32'h019);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b1; send(8'h1B); ovf_clr = 1'b0;
    chk("t4_ovf_set_wins", 32'(ovf), 32'd1);
    chk("t4_press_drop", 32'(press_cnt), 32'd11);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    bus.evt_ready = 1'b1;
    send(8'h1A);
    chk("t4_full_pop_push", 32'(ovf), 32'd0);
    idle(DEPTH + 4);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(10'h010 + 10'(i));
    exp_q.push_back(10'h01A);
    chk_events("t4_evt");
    chk("t4_drained", 32'(bus.evt_valid), 32'd0);

    // prefix timeout and receive errors
    do_reset();
    bus.evt_ready = 1'b1;
    send(8'hF0);
    idle(TO - 1);
    chk("t5_to_hold", 32'(fsm_state), 32'(ST_BRK));
    idle(1);
    chk("t5_to_fire", 32'(fsm_state), 32'(ST_IDLE));
    send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C);
    chk_events("t5_after_to");
    send(8'h2A, 1'b1);
    chk("t5_err1", 32'(err_cnt), 32'd1);
    send(8'hE0);
    send(8'h2A, 1'b1);
    chk("t5_err_idle", 32'(fsm_state), 32'(ST_IDLE));
    send(8'h22);
    idle(3);
    exp_q.push_back(10'h022);
    chk_events("t5_err_evt");
    for (int i = 0; i < 260; i++) send(8'h2A, 1'b1);
    chk("t5_err_sat", 32'(err_cnt), 32'd255);
    idle(2);
    chk_events("t5_err_noevt");

    // auto-repeat
    do_reset();
    bus.evt_ready = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_press", 32'(press_cnt), 32'd1);
`else
    exp_q.push_back(10'h01C); exp_q.push_back(10'h01C);
    chk("t6_press", 32'(press_cnt), 32'd3);
`endif
    chk_events("t6_evt");

    // press counter wraps
    do_reset();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(8'h30 + 8'(i % 2));
      exp_q.push_back(10'h030 + 10'(i % 2));
    end
    idle(3);
    chk("t7_press_wrap", 32'(press_cnt), 32'd0);
    chk("t7_key_code", 32'(key_code), 32'h031);
    chk_events("t7_evt");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
